// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port 8-bit RAM (asynchronous read, write on
// the rising edge) between CPU byte accesses and video read bursts.
//
// Each granted access occupies one "slot" cycle. The slot drives the RAM pins
// for that cycle, and the access retires at the next edge. At retirement the
// read data is captured into the CPU or video output registers.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   cpuReq/cpuWrite/cpuAddress/cpuDataIn
//                              CPU request, held until cpuAck
//   cpuDataOut, cpuAck         read data and one-cycle completion pulse
//   vidStart, vidAddress       burst start pulse and base address
//   vidBusy                    burst in progress
//   vidData, vidValid, vidDone fetched byte, its strobe, and the last-byte strobe
//   ramWriteEnabled, ramAddress, ramDataIn, ramDataOut
//                              RAM pins
module ram_arbiter #(
  parameter int Bits        = 16,
  parameter int BurstLen    = 4,
  parameter int MaxVideoRun = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpuReq,
  input  logic            cpuWrite,
  input  logic [Bits-1:0] cpuAddress,
  input  logic [7:0]      cpuDataIn,
  output logic [7:0]      cpuDataOut,
  output logic            cpuAck,
  input  logic            vidStart,
  input  logic [Bits-1:0] vidAddress,
  output logic            vidBusy,
  output logic [7:0]      vidData,
  output logic            vidValid,
  output logic            vidDone,
  output logic            ramWriteEnabled,
  output logic [Bits-1:0] ramAddress,
  output logic [7:0]      ramDataIn,
  input  logic [7:0]      ramDataOut
);

  typedef enum logic {IDLE, ACTIVE} burst_state_t;
  typedef enum logic {OWNER_CPU, OWNER_VID} owner_t;

  burst_state_t    burstState;
  owner_t          slotOwner;
  logic            slotValid;
  logic            slotWrite;
  logic            slotLast;      // video slot carries the final byte of the burst
  logic [Bits-1:0] slotAddress;
  logic [7:0]      slotData;

  logic [Bits-1:0] vidPtr;
  logic [7:0]      issueCount;    // video bytes still to be granted
  logic [3:0]      runCount;      // consecutive video grants while the CPU waited

  logic cpuEligible;
  logic vidEligible;
  logic grantCpu;
  logic grantVid;
  logic lastRetire;

  // A CPU slot retiring at this edge is the request being acknowledged, so it
  // cannot be granted again at the same edge.
  assign cpuEligible = cpuReq && !(slotValid && slotOwner == OWNER_CPU);
  assign vidEligible = (burstState == ACTIVE) && (issueCount != 8'd0);

  // Video has priority until it has used up its run while the CPU waits.
  assign grantCpu = cpuEligible && (!vidEligible || runCount == 4'(MaxVideoRun));
  assign grantVid = vidEligible && !grantCpu;

  assign lastRetire = slotValid && slotOwner == OWNER_VID && slotLast;

  assign ramAddress      = slotAddress;
  assign ramDataIn       = slotData;
  // Gating with reset keeps a write in flight from landing on the reset edge.
  assign ramWriteEnabled = slotValid && slotWrite && slotOwner == OWNER_CPU && !reset;
  assign vidBusy         = (burstState == ACTIVE);

  always_ff @(posedge clk) begin
    if (reset) begin
      burstState  <= IDLE;
      slotValid   <= 1'b0;
      slotOwner   <= OWNER_CPU;
      slotWrite   <= 1'b0;
      slotLast    <= 1'b0;
      slotAddress <= '0;
      slotData    <= '0;
      vidPtr      <= '0;
      issueCount  <= '0;
      runCount    <= '0;
      cpuAck      <= 1'b0;
      cpuDataOut  <= '0;
      vidValid    <= 1'b0;
      vidData     <= '0;
      vidDone     <= 1'b0;
    end else begin
      // Retire the slot that occupied the RAM during the cycle just ending.
      cpuAck   <= slotValid && slotOwner == OWNER_CPU;
      vidValid <= slotValid && slotOwner == OWNER_VID;
      vidDone  <= lastRetire;
      if (slotValid && slotOwner == OWNER_CPU && !slotWrite)
        cpuDataOut <= ramDataOut;
      if (slotValid && slotOwner == OWNER_VID)
        vidData <= ramDataOut;

      // Issue the next slot. Address and data hold when nothing is granted.
      slotValid <= grantCpu || grantVid;
      if (grantCpu) begin
        slotOwner   <= OWNER_CPU;
        slotWrite   <= cpuWrite;
        slotLast    <= 1'b0;
        slotAddress <= cpuAddress;
        slotData    <= cpuDataIn;
      end else if (grantVid) begin
        slotOwner   <= OWNER_VID;
        slotWrite   <= 1'b0;
        slotLast    <= (issueCount == 8'd1);
        slotAddress <= vidPtr;
      end

      if (!cpuEligible || grantCpu)
        runCount <= '0;
      else if (grantVid)
        runCount <= runCount + 4'd1;

      case (burstState)
        IDLE: begin
          if (vidStart) begin
            vidPtr     <= vidAddress;
            issueCount <= 8'(BurstLen);
            burstState <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (grantVid) begin
            vidPtr     <= vidPtr + Bits'(1);
            issueCount <= issueCount - 8'd1;
          end
          if (lastRetire)
            burstState <= IDLE;
        end
        default: burstState <= IDLE;
      endcase
    end
  end

endmodule
